// File: rtl/note_feeder_pkg.sv
// Shared definitions for the note-track feeder. The hit judge and the display controller
// use the same state encoding and tempo defaults.
package note_feeder_pkg;

  typedef enum logic [2:0] {
    FEED_IDLE   = 3'd0,
    FEED_CLEAR  = 3'd1,
    FEED_RUN    = 3'd2,
    FEED_PAUSED = 3'd3,
    FEED_DRAIN  = 3'd4,
    FEED_DONE   = 3'd5
  } feed_state_t;

  localparam int DEF_TICKS_PER_STEP = 2500000;
  localparam int DEF_SONG_LEN       = 256;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DRAIN_STEPS    = 100;

  // PAUSED counts as active: the cycle in which pause drops must already advance the tempo.
  function automatic logic feed_active(input feed_state_t s);
    return (s == FEED_RUN) || (s == FEED_PAUSED) || (s == FEED_DRAIN);
  endfunction

endpackage

// File: rtl/note_feeder_tempo_divider.sv
// Tick counter for the track tempo. It counts while enabled and flags the wrap cycle.
module tempo_divider #(
  parameter int TICKS_PER_STEP = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICKS_PER_STEP - 1);

  logic [TW-1:0] tick;

  // A disabled counter holds its value, so a wrap that is held off fires once enable returns.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      tick <= '0;
    end else if (enable) begin
      tick <= (tick == LAST) ? '0 : tick + TW'(1);
    end
  end

  assign wrap = enable && (tick == LAST);

endmodule

// File: rtl/note_feeder.sv
// Song-ROM walker feeding the 100-bit note-track shifter: a clear pulse, one note per tempo
// step, zero padding until the track is empty, then done.
module note_feeder
  import note_feeder_pkg::*;
#(
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int SONG_LEN       = DEF_SONG_LEN,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DRAIN_STEPS    = DEF_DRAIN_STEPS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pause,
  input  logic              rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              note_out,
  output logic              shift,
  output logic              load_n,
  output logic              busy,
  output logic              done
);

  localparam int STEP_MAX = (SONG_LEN > DRAIN_STEPS) ? SONG_LEN : DRAIN_STEPS;
  localparam int SW       = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam logic [SW-1:0]     SONG_LAST  = SW'(SONG_LEN - 1);
  localparam logic [SW-1:0]     DRAIN_LAST = SW'(DRAIN_STEPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SONG_LEN - 1);

  feed_state_t   state;
  logic [SW-1:0] step;
  logic          tick_enable;
  logic          wrap;

  assign tick_enable = reset_n && !pause && feed_active(state);

  tempo_divider #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_tempo (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state == FEED_CLEAR),
    .enable (tick_enable),
    .wrap   (wrap)
  );

  // Downstream contract: shift is a one-cycle valid with no ready; note_out is meaningful
  // only while shift=1. shift follows pause in the same cycle, so a pause on the wrap cycle
  // withholds the strobe.
  assign shift = wrap;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= FEED_IDLE;
      step     <= '0;
      rom_addr <= '0;
      note_out <= 1'b0;
      load_n   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        FEED_IDLE, FEED_DONE: begin
          if (start) begin
            state    <= FEED_CLEAR;
            step     <= '0;
            rom_addr <= '0;
            load_n   <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        FEED_CLEAR: begin
          state  <= FEED_RUN;
          load_n <= 1'b1;
        end
        FEED_RUN, FEED_PAUSED: begin
          note_out <= rom_data;
          if (wrap && step == SONG_LAST) begin
            state <= FEED_DRAIN;
            step  <= '0;
          end else begin
            if (wrap) begin
              step <= step + SW'(1);
              if (rom_addr != ADDR_LAST) rom_addr <= rom_addr + ADDR_W'(1);
            end
            state <= pause ? FEED_PAUSED : FEED_RUN;
          end
        end
        FEED_DRAIN: begin
          note_out <= 1'b0;
          if (wrap) begin
            if (step == DRAIN_LAST) begin
              state <= FEED_DONE;
              step  <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step <= step + SW'(1);
            end
          end
        end
        default: state <= FEED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_feeder.sv
// Bench for note_feeder: small tempo and song, registered ROM model, cycle-level reference
// model of the play sequence, and a note scoreboard popped on every shift strobe.
module tb_note_feeder;

  localparam int T     = 4;
  localparam int SL    = 8;
  localparam int AW    = 8;
  localparam int DS    = 3;
  localparam int TOTAL = SL + DS;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          rom_data = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          note_out;
  logic          shift;
  logic          load_n;
  logic          busy;
  logic          done;

  logic rom_mem [SL] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_fails  = 0;

  note_feeder #(
    .TICKS_PER_STEP(T),
    .SONG_LEN      (SL),
    .ADDR_W        (AW),
    .DRAIN_STEPS   (DS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .pause   (pause),
    .rom_data(rom_data),
    .rom_addr(rom_addr),
    .note_out(note_out),
    .shift   (shift),
    .load_n  (load_n),
    .busy    (busy),
    .done    (done)
  );

  // Clock and synchronous ROM (data one cycle after the address).
  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_data <= (rom_addr < AW'(SL)) ? rom_mem[rom_addr[2:0]] : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
  typedef enum {M_IDLE, M_CLEAR, M_PLAY, M_DONE} mphase_t;

  mphase_t m = M_IDLE;
  int      act_cycles = 0;
  int      strobes = 0;
  int      done_rises = 0;
  bit      just_reset = 1'b0;
  logic    prev_done = 1'b0;
  logic    exp_q [$];

  always @(negedge clock) begin
    logic exp_shift;
    if (just_reset) begin
      check("reset_rom_addr", rom_addr, 0);
      check("reset_note_out", note_out, 0);
      check("reset_load_n", load_n, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
    end
    just_reset = 1'b0;

    exp_shift = reset_n && (m == M_PLAY) && !pause && ((act_cycles % T) == T - 1);
    check("shift", shift, exp_shift);
    check("load_n", load_n, (m != M_CLEAR));
    check("busy", busy, (m == M_CLEAR) || (m == M_PLAY));
    check("done", done, (m == M_DONE));
    check("rom_addr_range", (rom_addr <= AW'(SL - 1)), 1);
    if (shift === 1'b1) begin
      if (exp_q.size() == 0) check("note_unexpected", shift, 0);
      else check("note_out", note_out, exp_q.pop_front());
    end
    if (done === 1'b1 && prev_done !== 1'b1) done_rises++;
    prev_done = done;

    if (!reset_n) begin
      m = M_IDLE;
      exp_q.delete();
      just_reset = 1'b1;
    end else begin
      case (m)
        M_IDLE, M_DONE: begin
          if (start) begin
            m = M_CLEAR;
            for (int i = 0; i < TOTAL; i++) exp_q.push_back((i < SL) ? rom_mem[i] : 1'b0);
          end
        end
        M_CLEAR: begin
          m = M_PLAY;
          act_cycles = 0;
          strobes = 0;
        end
        M_PLAY: begin
          if (!pause) act_cycles++;
          if (exp_shift) begin
            strobes++;
            if (strobes == TOTAL) m = M_DONE;
          end
        end
        default: m = M_IDLE;
      endcase
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_shift(input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (shift === 1'b1) break;
    end
    check("shift_timeout", shift, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) break;
      cyc(1);
    end
    check("done_timeout", done, 1);
  endtask

  task automatic play_random(input bit hold_start, input int budget);
    for (int i = 0; i < budget; i++) begin
      pause = ($urandom_range(0, 4) == 0);
      start = hold_start ? 1'b1 : ($urandom_range(0, 7) == 0);
      cyc(1);
      if (done === 1'b1) break;
    end
    pause = 1'b0;
    if (!hold_start) start = 1'b0;
    check("play_done_timeout", done, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // Plain play with a 10-cycle pause beginning on a wrap cycle.
    pulse_start();
    wait_shift(20);
    wait_shift(20);
    pause = 1'b1;
    cyc(10);
    pause = 1'b0;
    wait_done(200);
    cyc(5);

    // start held through a play: replay only once DONE is reached.
    start = 1'b1;
    play_random(1'b1, 400);
    cyc(2);
    start = 1'b0;
    play_random(1'b0, 400);
    cyc(4);

    // One-cycle reset in the middle of RUN, then idle, then a fresh play.
    pulse_start();
    wait_shift(20);
    wait_shift(20);
    wait_shift(20);
    cyc(1);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(20);
    pulse_start();
    play_random(1'b0, 400);
    cyc(4);

    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_rises, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
